// File: rtl/cam_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_cfg_pkg
// Description : Shared types and constants for the camera configuration
//               sequencer: state encoding, table marker values, the table
//               entry layout and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_cfg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_FETCH     = 3'd1;
    localparam state_t ST_ISSUE     = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_DELAY     = 3'd4;
    localparam state_t ST_NEXT      = 3'd5;
    localparam state_t ST_FINISH    = 3'd6;
    localparam state_t ST_ERROR     = 3'd7;

    localparam logic [15:0] CFG_DELAY_MARK = 16'hFFF0;
    localparam logic [15:0] CFG_END_MARK   = 16'hFFFF;

    // Register address occupies the upper byte so a raw 16-bit table word
    // reads naturally as {reg, value}.
    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] value;
    } cfg_entry_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_cfg_rom.sv
`default_nettype none
// ============================================================================
// Module      : cam_cfg_rom
// Description : Camera register table. Purely combinational lookup; camera
//               variants replace only this file. Unlisted indices return the
//               end marker.
// Ports       : idx_i   - table index
//               entry_o - {reg, value} entry at idx_i
// Revision    : 1.0 - initial release
// ============================================================================
module cam_cfg_rom
    import cam_cfg_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0] idx_i,
    output cfg_entry_t       entry_o
);

    always_comb begin
        entry_o = CFG_END_MARK;
        case (32'(idx_i))
            32'd0:   entry_o = '{reg_addr: 8'h12, value: 8'h80};  // soft reset
            32'd1:   entry_o = '{reg_addr: 8'h11, value: 8'h01};  // clock prescale
            32'd2:   entry_o = CFG_DELAY_MARK;                    // settle after reset
            32'd3:   entry_o = '{reg_addr: 8'h0C, value: 8'h04};  // output format
            default: entry_o = CFG_END_MARK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cam_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : cam_cfg_seq
// Description : Walks the camera register table and issues one 3-byte I2C
//               write (slave addr, reg, value) per entry through the I2C
//               master's transaction port. Handles delay and end markers.
//               Optional macro CAM_CFG_TIMEOUT_EN adds a WAIT_DONE watchdog
//               that moves to ERROR and raises error_o.
// Ports       : clk_i, rst_n_i (async, active-low)
//               start_i              - run the table from entry 0
//               busy_o/done_o        - run status / completion pulse
//               error_o              - sticky timeout flag
//               cfg_idx_o            - entry currently processed
//               i2c_send_o/nbytes_o/data_o - request to I2C master
//               i2c_done_i/ready_i   - I2C master status
// Revision    : 1.0 - initial release
// ============================================================================
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter logic [7:0] SLV_ADDR_G     = 8'h42,
    parameter int         NREGS_G        = 64,
    parameter int         DELAY_CYCLES_G = 1_000_000,
    parameter int         TIMEOUT_G      = 200_000
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [idx_width(NREGS_G)-1:0] cfg_idx_o,
    output logic                          i2c_send_o,
    output logic [1:0]                    i2c_nbytes_o,
    output logic [23:0]                   i2c_data_o,
    input  logic                          i2c_done_i,
    input  logic                          i2c_ready_i
);

    localparam int IDX_W = idx_width(NREGS_G);
    localparam int DLY_W = idx_width(DELAY_CYCLES_G);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NREGS_G - 1);
    localparam logic [DLY_W-1:0] C_DLY_LAST = DLY_W'(DELAY_CYCLES_G - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_data;
    logic             r_send;
    logic [DLY_W-1:0] r_dly_cnt;
    cfg_entry_t       w_entry;
    logic [15:0]      w_entry_raw;

`ifdef CAM_CFG_TIMEOUT_EN
    localparam int TO_W = idx_width(TIMEOUT_G);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_G - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_error;
    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

    cam_cfg_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .idx_i   (r_idx),
        .entry_o (w_entry)
    );

    assign w_entry_raw = w_entry;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_data    <= {16'h0000, SLV_ADDR_G};
            r_send    <= 1'b0;
            r_dly_cnt <= '0;
`ifdef CAM_CFG_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_error   <= 1'b0;
`endif
        end else begin
            r_send <= 1'b0;
            case (r_state)
                // ERROR behaves like IDLE for restart; error_o stays set
                // until the restart is accepted.
                ST_IDLE, ST_ERROR: begin
                    if (start_i) begin
                        r_state <= ST_FETCH;
                        r_idx   <= '0;
`ifdef CAM_CFG_TIMEOUT_EN
                        r_error <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    // Byte 0 travels in the LSBs; data holds until next FETCH.
                    r_data <= {w_entry.value, w_entry.reg_addr, SLV_ADDR_G};
                    if (w_entry_raw == CFG_END_MARK) begin
                        r_state <= ST_FINISH;
                    end else if (w_entry_raw == CFG_DELAY_MARK) begin
                        r_state   <= ST_DELAY;
                        r_dly_cnt <= '0;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Waiting on ready also absorbs the master's post-stop hold.
                    if (i2c_ready_i) begin
                        r_send  <= 1'b1;
                        r_state <= ST_WAIT_DONE;
`ifdef CAM_CFG_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (i2c_done_i) begin
                        r_state <= ST_NEXT;
`ifdef CAM_CFG_TIMEOUT_EN
                    end else if (r_to_cnt == C_TO_LAST) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                ST_DELAY: begin
                    if (r_dly_cnt == C_DLY_LAST) begin
                        r_state <= ST_NEXT;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    // Last table slot terminates the run even without a marker.
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = (r_state == ST_FETCH) || (r_state == ST_ISSUE) ||
                          (r_state == ST_WAIT_DONE) || (r_state == ST_DELAY) ||
                          (r_state == ST_NEXT);
    assign done_o       = (r_state == ST_FINISH);
    assign cfg_idx_o    = r_idx;
    assign i2c_send_o   = r_send;
    assign i2c_nbytes_o = 2'd2;
    assign i2c_data_o   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_cam_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_cfg_seq
// Description : Self-checking bench for cam_cfg_seq with a randomized I2C
//               master responder and a table-walk reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_cfg_seq;

    localparam int         C_DELAY    = 100;
    localparam int         C_TIMEOUT  = 1000;
    localparam int         C_NREGS    = 64;
    localparam int         C_HOLD_MAX = 20;
    localparam logic [7:0] C_SLV      = 8'h42;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, error_o, i2c_send_o;
    logic [5:0]  cfg_idx_o;
    logic [1:0]  i2c_nbytes_o;
    logic [23:0] i2c_data_o;
    logic        i2c_done_i = 1'b0;
    logic        i2c_ready_i = 1'b0;

    logic        start2 = 1'b0;
    logic        busy2, done2, error2, send2;
    logic [0:0]  idx2;
    logic [1:0]  nb2;
    logic [23:0] data2;
    logic        done2_i = 1'b0;

    always #5 clk_i = ~clk_i;

    cam_cfg_seq #(
        .SLV_ADDR_G(C_SLV), .NREGS_G(C_NREGS),
        .DELAY_CYCLES_G(C_DELAY), .TIMEOUT_G(C_TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .cfg_idx_o(cfg_idx_o), .i2c_send_o(i2c_send_o),
        .i2c_nbytes_o(i2c_nbytes_o), .i2c_data_o(i2c_data_o),
        .i2c_done_i(i2c_done_i), .i2c_ready_i(i2c_ready_i)
    );

    // Two-entry table: must stop after entry 1 with no end marker seen.
    cam_cfg_seq #(
        .SLV_ADDR_G(C_SLV), .NREGS_G(2),
        .DELAY_CYCLES_G(C_DELAY), .TIMEOUT_G(C_TIMEOUT)
    ) dut2 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start2),
        .busy_o(busy2), .done_o(done2), .error_o(error2),
        .cfg_idx_o(idx2), .i2c_send_o(send2),
        .i2c_nbytes_o(nb2), .i2c_data_o(data2),
        .i2c_done_i(done2_i), .i2c_ready_i(1'b1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: walk the camera table ---------------
    logic [15:0] tbl [5] = '{16'h1280, 16'h1101, 16'hFFF0, 16'h0C04, 16'hFFFF};
    logic [23:0] exp_data[$];
    int          exp_idx[$];
    int          exp_dly[$];

    function automatic void build_model(input int nregs);
        int d;
        logic [15:0] e;
        d = 0;
        exp_data.delete(); exp_idx.delete(); exp_dly.delete();
        for (int i = 0; i < nregs; i++) begin
            e = (i < 5) ? tbl[i] : 16'hFFFF;
            if (e == 16'hFFFF) break;
            if (e == 16'hFFF0) begin
                d++;
            end else begin
                exp_data.push_back({e[7:0], e[15:8], C_SLV});
                exp_idx.push_back(i);
                exp_dly.push_back(d);
                d = 0;
            end
        end
    endfunction

    // ---------------- monitor + I2C master responder ------------------------
    int          cyc = 0;
    logic [23:0] got_data[$];
    int          got_idx[$];
    int          got_cyc[$];
    int          got_done[$];
    int          n_viol = 0, n_dpulse = 0, err_cyc = -1, rise_cyc = 0;
    int          drop_idx = -1, lat_fix = 40;
    bit          force_low = 1'b0;
    int          m_cnt = 0, m_hold = 0;
    bit          m_active = 1'b0, m_drop = 1'b0, prev_send = 1'b0, prev_done = 1'b0;
    bit          new_rdy;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(negedge clk_i);
        if (i2c_send_o === 1'b1) begin
            if (i2c_ready_i !== 1'b1 || prev_send) n_viol++;
            if (i2c_nbytes_o !== 2'd2) n_viol++;
            got_data.push_back(i2c_data_o);
            got_idx.push_back(int'(cfg_idx_o));
            got_cyc.push_back(cyc);
        end
        if (done_o === 1'b1) begin
            n_dpulse++;
            if (busy_o !== 1'b0 || prev_done) n_viol++;
        end
        prev_send = (i2c_send_o === 1'b1);
        prev_done = (done_o === 1'b1);
        if (error_o === 1'b1 && err_cyc < 0) err_cyc = cyc;

        i2c_done_i = 1'b0;
        if (!rst_n_i) begin
            m_active = 1'b0;
            m_hold   = 0;
        end else if (m_active) begin
            m_cnt--;
            if (m_cnt <= 0) begin
                m_active = 1'b0;
                m_hold   = $urandom_range(0, C_HOLD_MAX);
                if (!m_drop) begin
                    i2c_done_i = 1'b1;
                    got_done.push_back(cyc);
                end
            end
        end else if (i2c_send_o === 1'b1) begin
            m_active = 1'b1;
            m_drop   = (int'(cfg_idx_o) == drop_idx);
            m_cnt    = (lat_fix > 0) ? lat_fix : int'($urandom_range(5, 60));
        end else if (m_hold > 0) begin
            m_hold--;
        end
        new_rdy = rst_n_i && !m_active && (m_hold == 0) && !force_low;
        if (new_rdy && !i2c_ready_i) rise_cyc = cyc;
        i2c_ready_i = new_rdy;
    end

    // Simple always-ready responder for the two-entry instance.
    logic [23:0] got2[$];
    int          cnt2 = 0, n_done2 = 0;
    initial forever begin
        @(negedge clk_i);
        done2_i = 1'b0;
        if (done2 === 1'b1) n_done2++;
        if (send2 === 1'b1) begin
            got2.push_back(data2);
            cnt2 = 3;
        end else if (cnt2 > 0) begin
            cnt2--;
            if (cnt2 == 0) done2_i = 1'b1;
        end
    end

    // ---------------- helpers ------------------------------------------------
    task automatic clear_got();
        got_data.delete(); got_idx.delete(); got_cyc.delete(); got_done.delete();
        n_viol = 0; n_dpulse = 0; err_cyc = -1;
    endtask

    task automatic pulse_start(output int s_cyc);
        @(negedge clk_i);
        start_i = 1'b1;
        s_cyc   = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sends(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i);
            if (got_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_run(input string tag);
        int gap;
        chk({tag, "_nsend"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            chk($sformatf("%s_idx%0d", tag, i), got_idx[i], exp_idx[i]);
            if (i > 0 && exp_dly[i] > 0 && got_done.size() >= i) begin
                gap = got_cyc[i] - got_done[i-1];
                chk($sformatf("%s_gap_lo%0d(gap=%0d)", tag, i, gap),
                    gap >= exp_dly[i] * C_DELAY, 1);
                chk($sformatf("%s_gap_hi%0d(gap=%0d)", tag, i, gap),
                    gap <= exp_dly[i] * (C_DELAY + 2) + 4, 1);
            end
        end
        chk({tag, "_ndone"}, n_dpulse, 1);
        chk({tag, "_busy_after"}, busy_o, 1'b0);
        chk({tag, "_protocol"}, n_viol, 0);
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        bit ok;
        int s0, snap, rise_snap, t;

        build_model(C_NREGS);
        repeat (3) @(negedge clk_i);
        chk("rst_busy",  busy_o,     1'b0);
        chk("rst_done",  done_o,     1'b0);
        chk("rst_error", error_o,    1'b0);
        chk("rst_send",  i2c_send_o, 1'b0);
        chk("rst_data",  i2c_data_o, {16'h0000, C_SLV});
        chk("rst_idx",   cfg_idx_o,  6'd0);
        rst_n_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // Run 1: fixed 40-cycle done latency, start-to-send latency.
        clear_got();
        lat_fix = 40;
        pulse_start(s0);
        chk("run1_busy_start", busy_o, 1'b1);
        wait_done(3000, ok);
        chk("run1_completed", ok, 1'b1);
        @(negedge clk_i);
        chk("run1_done_width", done_o, 1'b0);
        check_run("run1");
        if (got_cyc.size() > 0) chk("run1_latency", got_cyc[0] - s0, 3);

        // Randomized done latency and master hold time.
        for (int r = 0; r < 4; r++) begin
            clear_got();
            lat_fix = -1;
            pulse_start(s0);
            wait_done(3000, ok);
            chk($sformatf("rand%0d_completed", r), ok, 1'b1);
            @(negedge clk_i);
            check_run($sformatf("rand%0d", r));
            repeat ($urandom_range(1, 30)) @(negedge clk_i);
        end

        // Ready held low for 500 cycles after start.
        force_low = 1'b1;
        repeat (25) @(negedge clk_i);
        clear_got();
        lat_fix = -1;
        pulse_start(s0);
        repeat (500) @(negedge clk_i);
        chk("ready_low_nosend", got_data.size(), 0);
        chk("ready_low_busy", busy_o, 1'b1);
        force_low = 1'b0;
        repeat (3) @(negedge clk_i);
        rise_snap = rise_cyc;
        wait_done(3000, ok);
        chk("ready_low_completed", ok, 1'b1);
        @(negedge clk_i);
        check_run("ready_low");
        if (got_cyc.size() > 0) chk("ready_rise_to_send", got_cyc[0] - rise_snap, 1);

        // start_i while busy must be ignored.
        repeat (10) @(negedge clk_i);
        clear_got();
        lat_fix = 40;
        pulse_start(s0);
        wait_sends(1, 500, ok);
        chk("midstart_first_send", ok, 1'b1);
        snap = int'(cfg_idx_o);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("midstart_idx", cfg_idx_o, snap);
        chk("midstart_busy", busy_o, 1'b1);
        wait_done(3000, ok);
        chk("midstart_completed", ok, 1'b1);
        @(negedge clk_i);
        check_run("midstart");

`ifdef CAM_CFG_TIMEOUT_EN
        // Done never returned on entry 1.
        repeat (10) @(negedge clk_i);
        clear_got();
        lat_fix  = 20;
        drop_idx = 1;
        pulse_start(s0);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (error_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_error_seen", ok, 1'b1);
        if (got_cyc.size() >= 2) chk("to_error_time", err_cyc - got_cyc[1], C_TIMEOUT);
        chk("to_idx_frozen", cfg_idx_o, 6'd1);
        chk("to_busy_low", busy_o, 1'b0);
        repeat (100) @(negedge clk_i);
        chk("to_no_more_sends", got_data.size(), 2);
        chk("to_error_sticky", error_o, 1'b1);
        drop_idx = -1;
        clear_got();
        pulse_start(s0);
        chk("to_restart_clear", error_o, 1'b0);
        chk("to_restart_busy", busy_o, 1'b1);
        wait_done(3000, ok);
        chk("to_restart_completed", ok, 1'b1);
        @(negedge clk_i);
        check_run("to_restart");
`endif

        // Asynchronous reset during WAIT_DONE.
        repeat (10) @(negedge clk_i);
        clear_got();
        lat_fix = 40;
        pulse_start(s0);
        wait_sends(2, 500, ok);
        chk("arst_reach_wait", ok, 1'b1);
        repeat (5) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_busy",  busy_o,     1'b0);
        chk("arst_done",  done_o,     1'b0);
        chk("arst_error", error_o,    1'b0);
        chk("arst_send",  i2c_send_o, 1'b0);
        chk("arst_data",  i2c_data_o, {16'h0000, C_SLV});
        chk("arst_idx",   cfg_idx_o,  6'd0);
        @(negedge clk_i);
        start_i = 1'b1;
        repeat (2) @(negedge clk_i);
        start_i = 1'b0;
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("arst_start_ignored", busy_o, 1'b0);
        clear_got();
        lat_fix = -1;
        pulse_start(s0);
        wait_done(3000, ok);
        chk("arst_rerun_completed", ok, 1'b1);
        @(negedge clk_i);
        check_run("arst_rerun");

        // Two-entry table terminates after its last slot.
        build_model(2);
        @(negedge clk_i);
        start2 = 1'b1;
        @(negedge clk_i);
        start2 = 1'b0;
        t = 0;
        while (n_done2 == 0 && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        chk("last_slot_completed", n_done2, 1);
        chk("last_slot_nsend", got2.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got2.size(); i++)
            chk($sformatf("last_slot_data%0d", i), got2[i], exp_data[i]);
        chk("last_slot_idx", idx2, 1'b1);
        chk("last_slot_busy", busy2, 1'b0);
        chk("last_slot_error", error2, 1'b0);
        chk("last_slot_nbytes", nb2, 2'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_cfg_seq.md
Name: cam_cfg_seq

Overview:
Camera register configuration sequencer that drives the I2C master's transaction port (send/nbytes/data/done/ready) through a fixed table of camera register writes.
- On start_i it walks the table and issues one 3-byte write per entry: slave address, register address, register value.
- Honours in-table delay and end markers.
- Reports busy/done/error to the top-level camera controller.
- Sits between the top-level controller and the I2C master; it is the only requester of that master during configuration.

Parameters:
SLV_ADDR_G, 8'h42, 8-bit camera write address (R/W bit = 0) sent as byte 0.
NREGS_G, 64, table depth in entries; index width = $clog2(NREGS_G).
DELAY_CYCLES_G, 1_000_000, clk_i cycles waited on a delay marker entry.
TIMEOUT_G, 200_000, clk_i cycles allowed between send pulse and i2c_done_i (used only with CAM_CFG_TIMEOUT_EN).

Ports:
clk_i  in  1  system clock, single clock domain.
rst_n_i  in  1  reset, asynchronous, active-low.
start_i  in  1  one-cycle request to run the table from entry 0.
busy_o  out  1  high from the cycle after an accepted start_i until done_o/error_o.
done_o  out  1  one-cycle pulse when the table completes.
error_o  out  1  sticky timeout flag; cleared on the next accepted start_i.
cfg_idx_o  out  $clog2(NREGS_G)  index of the entry currently being processed.
i2c_send_o  out  1  one-cycle transaction request to the I2C master.
i2c_nbytes_o  out  2  bytes after the address byte; constant 2'd2.
i2c_data_o  out  24  {value[23:16], reg[15:8], SLV_ADDR_G[7:0]}; byte 0 = LSB byte.
i2c_done_i  in  1  one-cycle pulse from the I2C master at end of transaction.
i2c_ready_i  in  1  I2C master idle and able to accept i2c_send_o.

Behaviour:
- Reset (async assert): state IDLE; idx=0; busy_o=0, done_o=0, error_o=0, i2c_send_o=0; i2c_data_o=24'h000000 with SLV_ADDR_G in the low byte; delay/timeout counters=0.
- Table entry: 16 bits {reg, value}.
  - 16'hFFF0 = delay marker.
  - 16'hFFFF = end marker.
  - Reaching idx=NREGS_G-1 without an end marker behaves as an end marker after that entry is processed.
- FSM states: IDLE, FETCH, ISSUE, WAIT_DONE, DELAY, NEXT, FINISH, ERROR.
- IDLE: start_i -> FETCH, idx=0, error_o cleared.
- FETCH: register the entry into i2c_data_o (stable until the next FETCH).
  - End marker -> FINISH.
  - Delay marker -> DELAY.
  - Otherwise -> ISSUE.
- ISSUE: wait for i2c_ready_i=1, then assert i2c_send_o for exactly one cycle -> WAIT_DONE.
  - i2c_send_o is never high while i2c_ready_i=0.
- WAIT_DONE: i2c_done_i -> NEXT. i2c_done_i seen in any other state is ignored.
- DELAY: count DELAY_CYCLES_G cycles; the last count -> NEXT.
- NEXT: idx==NREGS_G-1 -> FINISH; else idx+1 -> FETCH.
  - The ISSUE wait for i2c_ready_i absorbs the master's free-hold interval.
- FINISH: done_o=1 for one cycle, busy_o drops the same cycle -> IDLE.
- ERROR: error_o=1, busy_o=0; start_i -> FETCH (restart from idx 0).
- start_i while busy is ignored. start_i coincident with reset is ignored.
- Latency: start_i to first i2c_send_o = 3 cycles when i2c_ready_i is already high (FETCH, ISSUE, pulse).
- Reset mid-transaction: the sequencer returns to IDLE immediately. The I2C master is expected to share rst_n_i.

Optional Feature:
CAM_CFG_TIMEOUT_EN.
- Defined: a counter runs in WAIT_DONE. Reaching TIMEOUT_G without i2c_done_i -> ERROR, with error_o set and cfg_idx_o frozen at the failing entry.
- Undefined: no counter; WAIT_DONE waits indefinitely; error_o is tied 0.

Decomposition:
- Package cam_cfg_pkg holds:
  - state_t enum;
  - constants CFG_DELAY_MARK = 16'hFFF0 and CFG_END_MARK = 16'hFFFF;
  - the cfg_entry_t struct {reg, value}.
- Sub-module cam_cfg_rom: combinational case-based table indexed by idx, returning cfg_entry_t, so camera variants swap only the ROM.

Test Plan:
1. Table {12:80, 11:01, FFFF}, ready tied 1, done modeled 40 cycles after send.
   - Expect exactly 2 sends: i2c_data_o = 24'h801242, then 24'h011142; nbytes=2.
   - Expect done_o one cycle, busy_o low afterwards.
2. Table {12:80, FFF0, 11:01, FFFF}, DELAY_CYCLES_G=100.
   - Second send occurs no earlier than 100 cycles after the first done.
3. i2c_ready_i held 0 for 500 cycles after start_i: i2c_send_o stays 0; then a single one-cycle pulse 1 cycle after ready rises.
4. start_i pulsed again mid-run: no restart, idx unchanged, total send count unchanged.
5. With CAM_CFG_TIMEOUT_EN, TIMEOUT_G=1000, done never returned on entry 1:
   - error_o=1 at send+1000 cycles, cfg_idx_o=1, no further sends.
   - Next start_i clears error_o and restarts at idx 0.
6. rst_n_i asserted during WAIT_DONE: all outputs return to reset values asynchronously; a new start_i runs the table from entry 0.
